// File: rtl/pa_fpu_pkg.sv
// Shared FPU writeback-scheduler types: widths, FSM state encoding and one-hot source tags.
package pa_fpu_pkg;

    localparam int FPU_DATA_W  = 32;
    localparam int FPU_FFLAG_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        STARVE = 2'd2
    } wbs_state_t;

    localparam logic [1:0] WBS_SRC_EX2  = 2'b01;
    localparam logic [1:0] WBS_SRC_FDSU = 2'b10;

    typedef struct packed {
        logic [FPU_DATA_W-1:0]  data;
        logic [FPU_FFLAG_W-1:0] fflags;
    } wbs_res_t;

endpackage

// File: rtl/pa_fpu_wb_sched_if.sv
// Writeback-scheduler bus: producer requests from EX2/FDSU and the shared forward/writeback result.
interface pa_fpu_wb_sched_if;
    import pa_fpu_pkg::*;

    logic                   rtu_wbs_flush;
    logic                   ctrl_wbs_ex2_wb_req;
    logic [FPU_DATA_W-1:0]  dp_wbs_ex2_data;
    logic [FPU_FFLAG_W-1:0] dp_wbs_ex2_fflags;
    logic                   fdsu_wbs_wb_vld;
    logic [FPU_DATA_W-1:0]  fdsu_wbs_data;
    logic [FPU_FFLAG_W-1:0] fdsu_wbs_fflags;
    logic                   wbs_fdsu_wb_rdy;
    logic                   wbs_idu_issue_stall;
    logic                   fpu_idu_fwd_vld;
    logic [FPU_DATA_W-1:0]  fpu_idu_fwd_data;
    logic [FPU_FFLAG_W-1:0] fpu_idu_fwd_fflags;
    logic [1:0]             fpu_idu_fwd_src;

    modport master (
        output rtu_wbs_flush, ctrl_wbs_ex2_wb_req, dp_wbs_ex2_data, dp_wbs_ex2_fflags,
               fdsu_wbs_wb_vld, fdsu_wbs_data, fdsu_wbs_fflags,
        input  wbs_fdsu_wb_rdy, wbs_idu_issue_stall, fpu_idu_fwd_vld, fpu_idu_fwd_data,
               fpu_idu_fwd_fflags, fpu_idu_fwd_src
    );

    modport slave (
        input  rtu_wbs_flush, ctrl_wbs_ex2_wb_req, dp_wbs_ex2_data, dp_wbs_ex2_fflags,
               fdsu_wbs_wb_vld, fdsu_wbs_data, fdsu_wbs_fflags,
        output wbs_fdsu_wb_rdy, wbs_idu_issue_stall, fpu_idu_fwd_vld, fpu_idu_fwd_data,
               fpu_idu_fwd_fflags, fpu_idu_fwd_src
    );

endinterface

// File: rtl/pa_fpu_wb_buf.sv
// FDSU holding FIFO: DEPTH entries of {data,fflags}, wrapping pointers, synchronous flush.
module pa_fpu_wb_buf
    import pa_fpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  wbs_res_t         push_data,
    input  logic             pop,
    output wbs_res_t         head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    wbs_res_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pa_fpu_wb_sched.sv
// FPU writeback scheduler: EX2 always wins the result bus, FDSU results queue behind it in order.
// Optional PA_FPU_WB_SCHED_PERF_EN adds a saturating bus-collision counter output.
//
//   state  | meaning
//   IDLE   | buffer empty, no stall
//   PEND   | buffered FDSU result waiting, age below STARVE_MAX
//   STARVE | head waited STARVE_MAX cycles, IDU issue stalled
module pa_fpu_wb_sched
    import pa_fpu_pkg::*;
#(
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                 forever_cpuclk,
    input  logic                 cpurst,
    pa_fpu_wb_sched_if.slave     wbs
`ifdef PA_FPU_WB_SCHED_PERF_EN
    ,
    output logic [15:0]          wbs_perf_coll_cnt
`endif
);

    localparam int         CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

    wbs_state_t       state;
    logic [3:0]       age;
    logic [3:0]       age_nxt;
    wbs_res_t         head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic             buf_full;
    logic             buf_empty;
    logic             flush;
    logic             ex2_req;
    logic             ex2_win;
    logic             buf_win;
    logic             dir_win;
    logic             fdsu_acc;
    logic             push;

    assign flush    = wbs.rtu_wbs_flush;
    assign ex2_req  = wbs.ctrl_wbs_ex2_wb_req;
    assign fdsu_acc = wbs.fdsu_wbs_wb_vld && !buf_full && !flush;
    assign ex2_win  = ex2_req && !flush;
    assign buf_win  = !ex2_req && !buf_empty && !flush;
    assign dir_win  = !ex2_req && buf_empty && fdsu_acc;
    // A new FDSU result may only bypass the buffer when nothing older is queued.
    assign push     = fdsu_acc && (ex2_req || !buf_empty);
    assign cnt_nxt  = count + CNT_W'(push) - CNT_W'(buf_win);

    assign wbs.wbs_fdsu_wb_rdy = !buf_full;

    pa_fpu_wb_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .flush     (flush),
        .push      (push),
        .push_data ('{data: wbs.fdsu_wbs_data, fflags: wbs.fdsu_wbs_fflags}),
        .pop       (buf_win),
        .head      (head),
        .count     (count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        age_nxt = '0;
        if (!flush && !buf_win && !buf_empty) begin
            age_nxt = (age == AGE_MAX) ? age : age + 4'd1;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) age <= '0;
        else        age <= age_nxt;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || flush) begin
            state                   <= IDLE;
            wbs.wbs_idu_issue_stall <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (push) state <= PEND;
                    wbs.wbs_idu_issue_stall <= 1'b0;
                end
                PEND: begin
                    if (cnt_nxt == '0) begin
                        state <= IDLE;
                    end else if (age_nxt == AGE_MAX) begin
                        state                   <= STARVE;
                        wbs.wbs_idu_issue_stall <= 1'b1;
                    end
                end
                STARVE: begin
                    if (cnt_nxt == '0) begin
                        state                   <= IDLE;
                        wbs.wbs_idu_issue_stall <= 1'b0;
                    end else if (buf_win) begin
                        state                   <= PEND;
                        wbs.wbs_idu_issue_stall <= 1'b0;
                    end
                end
                default: begin
                    state                   <= IDLE;
                    wbs.wbs_idu_issue_stall <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst || flush) begin
            wbs.fpu_idu_fwd_vld    <= 1'b0;
            wbs.fpu_idu_fwd_data   <= '0;
            wbs.fpu_idu_fwd_fflags <= '0;
            wbs.fpu_idu_fwd_src    <= 2'b00;
        end else if (ex2_win) begin
            wbs.fpu_idu_fwd_vld    <= 1'b1;
            wbs.fpu_idu_fwd_data   <= wbs.dp_wbs_ex2_data;
            wbs.fpu_idu_fwd_fflags <= wbs.dp_wbs_ex2_fflags;
            wbs.fpu_idu_fwd_src    <= WBS_SRC_EX2;
        end else if (buf_win) begin
            wbs.fpu_idu_fwd_vld    <= 1'b1;
            wbs.fpu_idu_fwd_data   <= head.data;
            wbs.fpu_idu_fwd_fflags <= head.fflags;
            wbs.fpu_idu_fwd_src    <= WBS_SRC_FDSU;
        end else if (dir_win) begin
            wbs.fpu_idu_fwd_vld    <= 1'b1;
            wbs.fpu_idu_fwd_data   <= wbs.fdsu_wbs_data;
            wbs.fpu_idu_fwd_fflags <= wbs.fdsu_wbs_fflags;
            wbs.fpu_idu_fwd_src    <= WBS_SRC_FDSU;
        end else begin
            wbs.fpu_idu_fwd_vld    <= 1'b0;
            wbs.fpu_idu_fwd_data   <= '0;
            wbs.fpu_idu_fwd_fflags <= '0;
            wbs.fpu_idu_fwd_src    <= 2'b00;
        end
    end

`ifdef PA_FPU_WB_SCHED_PERF_EN
    logic coll;
    // Flushed cycles are not counted; the counter itself survives flush.
    assign coll = ex2_req && !flush && (!buf_empty || wbs.fdsu_wbs_wb_vld);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst)                                   wbs_perf_coll_cnt <= '0;
        else if (coll && wbs_perf_coll_cnt != 16'hFFFF) wbs_perf_coll_cnt <= wbs_perf_coll_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pa_fpu_wb_sched.sv
// Bench for pa_fpu_wb_sched: directed table, then random traffic against a queue-based model.
module tb_pa_fpu_wb_sched;
    import pa_fpu_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pa_fpu_wb_sched_if bus ();

`ifdef PA_FPU_WB_SCHED_PERF_EN
    logic [15:0] perf_cnt;
`endif

    pa_fpu_wb_sched #(.BUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .forever_cpuclk (clk),
        .cpurst         (rst),
        .wbs            (bus)
`ifdef PA_FPU_WB_SCHED_PERF_EN
        ,
        .wbs_perf_coll_cnt (perf_cnt)
`endif
    );

    typedef struct {
        logic        flush;
        logic        req;
        logic [31:0] ed;
        logic [4:0]  ef;
        logic        fv;
        logic [31:0] fd;
        logic [4:0]  ff;
        logic        e_vld;
        logic [1:0]  e_src;
        logic [31:0] e_data;
        logic [4:0]  e_ff;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t     tbl[$];
    wbs_res_t q[$];
    int       age;
    int       m_perf;
    logic [41:0] m_exp;
    int       tests;
    int       fails;

    function automatic logic [41:0] pack(input logic vld, input logic [1:0] src,
                                         input logic [31:0] data, input logic [4:0] ff,
                                         input logic rdy, input logic stall);
        return {vld, src, data, ff, rdy, stall};
    endfunction

    task automatic check(input string name, input int idx, input logic [41:0] act, input logic [41:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d] got {vld,src,data,ff,rdy,stall}=%h want %h", name, idx, act, exp);
        end
    endtask

    // Reference: queue of waiting FDSU results, EX2 > oldest queued > direct FDSU.
    task automatic model_step(input vec_t v);
        int       sz;
        logic     acc;
        logic     deq;
        logic     o_vld;
        logic [1:0] o_src;
        wbs_res_t o_res;
        sz    = q.size();
        acc   = v.fv && (sz < DEPTH);
        deq   = 1'b0;
        o_vld = 1'b0;
        o_src = 2'b00;
        o_res = '0;
        if (v.flush) begin
            q.delete();
            age = 0;
        end else begin
            if (v.req && (sz > 0 || v.fv) && m_perf < 65535) m_perf++;
            if (v.req) begin
                o_vld = 1'b1; o_src = 2'b01; o_res = '{data: v.ed, fflags: v.ef};
            end else if (sz > 0) begin
                o_vld = 1'b1; o_src = 2'b10; o_res = q.pop_front(); deq = 1'b1;
            end else if (acc) begin
                o_vld = 1'b1; o_src = 2'b10; o_res = '{data: v.fd, fflags: v.ff};
            end
            if (acc && (v.req || sz > 0)) q.push_back('{data: v.fd, fflags: v.ff});
            if (deq)         age = 0;
            else if (sz > 0) age = (age + 1 > SMAX) ? SMAX : age + 1;
            else             age = 0;
        end
        m_exp = pack(o_vld, o_src, o_res.data, o_res.fflags,
                     q.size() < DEPTH, (q.size() > 0) && (age == SMAX));
    endtask

    task automatic run_vec(input vec_t v, input bit use_tbl, input int idx);
        logic [41:0] act;
        @(negedge clk);
        bus.rtu_wbs_flush       = v.flush;
        bus.ctrl_wbs_ex2_wb_req = v.req;
        bus.dp_wbs_ex2_data     = v.ed;
        bus.dp_wbs_ex2_fflags   = v.ef;
        bus.fdsu_wbs_wb_vld     = v.fv;
        bus.fdsu_wbs_data       = v.fd;
        bus.fdsu_wbs_fflags     = v.ff;
        model_step(v);
        @(posedge clk);
        #1;
        act = pack(bus.fpu_idu_fwd_vld, bus.fpu_idu_fwd_src, bus.fpu_idu_fwd_data,
                   bus.fpu_idu_fwd_fflags, bus.wbs_fdsu_wb_rdy, bus.wbs_idu_issue_stall);
        check(use_tbl ? "table_model" : "rand_model", idx, act, m_exp);
        if (use_tbl) check("table_exp", idx, act,
                           pack(v.e_vld, v.e_src, v.e_data, v.e_ff, v.e_rdy, v.e_stall));
`ifdef PA_FPU_WB_SCHED_PERF_EN
        tests++;
        if (perf_cnt !== 16'(m_perf)) begin
            fails++;
            $display("FAIL perf_cnt[%0d] got %0d want %0d", idx, perf_cnt, m_perf);
        end
`endif
    endtask

    function automatic vec_t mk(input logic fl, input logic rq, input logic [31:0] ed, input logic [4:0] ef,
                                input logic fv, input logic [31:0] fd, input logic [4:0] ff,
                                input logic vld, input logic [1:0] src, input logic [31:0] d,
                                input logic [4:0] f, input logic rdy, input logic stall);
        vec_t v;
        v = '{fl, rq, ed, ef, fv, fd, ff, vld, src, d, f, rdy, stall};
        return v;
    endfunction

    initial begin
        vec_t v;
        tests  = 0;
        fails  = 0;
        age    = 0;
        m_perf = 0;
        rst = 1'b1;
        bus.rtu_wbs_flush = 1'b0; bus.ctrl_wbs_ex2_wb_req = 1'b0;
        bus.dp_wbs_ex2_data = '0; bus.dp_wbs_ex2_fflags = '0;
        bus.fdsu_wbs_wb_vld = 1'b0; bus.fdsu_wbs_data = '0; bus.fdsu_wbs_fflags = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", 0, pack(bus.fpu_idu_fwd_vld, bus.fpu_idu_fwd_src, bus.fpu_idu_fwd_data,
                               bus.fpu_idu_fwd_fflags, bus.wbs_fdsu_wb_rdy, bus.wbs_idu_issue_stall),
              pack(1'b0, 2'b00, 32'h0, 5'h0, 1'b1, 1'b0));
`ifdef PA_FPU_WB_SCHED_PERF_EN
        check("reset_perf", 0, {26'h0, perf_cnt}, 42'h0);
`endif
        rst = 1'b0;

        // EX2 alone
        tbl.push_back(mk(0,1,32'h3F800000,5'h01, 0,32'h0,5'h0,        1,2'b01,32'h3F800000,5'h01,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        0,2'b00,32'h0,5'h0,1,0));
        // collision: EX2 first, FDSU one cycle later
        tbl.push_back(mk(0,1,32'h11111111,5'h0,  1,32'h40000000,5'h02,1,2'b01,32'h11111111,5'h0,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        1,2'b10,32'h40000000,5'h02,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        0,2'b00,32'h0,5'h0,1,0));
        // full buffer with FDSU held: order entry0, entry1, new
        tbl.push_back(mk(0,1,32'h1,5'h0,         1,32'hE0,5'h03,      1,2'b01,32'h1,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h2,5'h0,         1,32'hE1,5'h04,      1,2'b01,32'h2,5'h0,0,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         1,32'hABCD0000,5'h05,1,2'b10,32'hE0,5'h03,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         1,32'hABCD0000,5'h05,1,2'b10,32'hE1,5'h04,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        1,2'b10,32'hABCD0000,5'h05,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        0,2'b00,32'h0,5'h0,1,0));
        // flush with EX2 req and a full buffer
        tbl.push_back(mk(0,1,32'h5,5'h0,         1,32'hDEAD0001,5'h06,1,2'b01,32'h5,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h6,5'h0,         1,32'hDEAD0002,5'h07,1,2'b01,32'h6,5'h0,0,0));
        tbl.push_back(mk(1,1,32'h7,5'h1,         1,32'hDEAD0003,5'h08,0,2'b00,32'h0,5'h0,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        0,2'b00,32'h0,5'h0,1,0));
        // starvation: head waits under continuous EX2 traffic
        tbl.push_back(mk(0,1,32'h100,5'h0,       1,32'h5A5A5A5A,5'h08,1,2'b01,32'h100,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h101,5'h0,       0,32'h0,5'h0,        1,2'b01,32'h101,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h102,5'h0,       0,32'h0,5'h0,        1,2'b01,32'h102,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h103,5'h0,       0,32'h0,5'h0,        1,2'b01,32'h103,5'h0,1,0));
        tbl.push_back(mk(0,1,32'h104,5'h0,       0,32'h0,5'h0,        1,2'b01,32'h104,5'h0,1,1));
        tbl.push_back(mk(0,1,32'h105,5'h0,       0,32'h0,5'h0,        1,2'b01,32'h105,5'h0,1,1));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        1,2'b10,32'h5A5A5A5A,5'h08,1,0));
        tbl.push_back(mk(0,0,32'h0,5'h0,         0,32'h0,5'h0,        0,2'b00,32'h0,5'h0,1,0));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 1'b1, i);

        for (int i = 0; i < 800; i++) begin
            v = mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 4), $urandom, 5'($urandom),
                   ($urandom_range(0, 1) == 1), $urandom, 5'($urandom),
                   0, 2'b00, 32'h0, 5'h0, 0, 0);
            run_vec(v, 1'b0, i);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
